// File: rtl/game_pkg.sv
// Shared types and default constants for the game sequencer.
package game_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  // Screen and paddle geometry
  localparam int unsigned DEF_X_MIN   = 0;
  localparam int unsigned DEF_X_MAX   = 800;
  localparam int unsigned DEF_PW      = 64;
  localparam int unsigned DEF_STEP    = 8;
  localparam int unsigned DEF_X1_INIT = 200;
  localparam int unsigned DEF_X2_INIT = 536;

  // Game rules
  localparam int unsigned DEF_LIVES_INIT  = 3;
  localparam int unsigned DEF_OVER_FRAMES = 120;
  localparam int unsigned DEF_SPEED_STEP  = 5;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Handshake between the game sequencer and square_logic.
interface game_sequencer_if;
  logic       hit1;
  logic       hit2;
  logic       sq_bottom;
  logic       move_en;
  logic       sq_respawn;
  logic [2:0] speed;

  modport master (
    input  hit1, hit2, sq_bottom,
    output move_en, sq_respawn, speed
  );

  modport slave (
    output hit1, hit2, sq_bottom,
    input  move_en, sq_respawn, speed
  );
endinterface

// File: rtl/paddle_step.sv
// One-step paddle move with clamping to the legal x range.
module paddle_step
  import game_pkg::*;
#(
  parameter int unsigned X_MIN = DEF_X_MIN,
  parameter int unsigned X_MAX = DEF_X_MAX,
  parameter int unsigned PW    = DEF_PW,
  parameter int unsigned STEP  = DEF_STEP
) (
  input  logic [9:0] pos,
  input  logic       left,
  input  logic       right,
  output logic [9:0] pos_next
);

  localparam logic [9:0] MIN_POS = 10'(X_MIN);
  localparam logic [9:0] MAX_POS = 10'(X_MAX - PW);
  localparam logic [9:0] L_TH    = 10'(X_MIN + STEP);
  localparam logic [9:0] R_TH    = 10'(X_MAX - PW - STEP);
  localparam logic [9:0] STEP_V  = 10'(STEP);

  // Opposing requests cancel; otherwise step and clamp without wrap
  always_comb begin
    pos_next = pos;
    if (left && !right) begin
      pos_next = (pos < L_TH) ? MIN_POS : pos - STEP_V;
    end else if (right && !left) begin
      pos_next = (pos > R_TH) ? MAX_POS : pos + STEP_V;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Frame-locked game controller: FSM, paddles, scores, lives and speed.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned X_MIN       = DEF_X_MIN,
  parameter int unsigned X_MAX       = DEF_X_MAX,
  parameter int unsigned PW          = DEF_PW,
  parameter int unsigned STEP        = DEF_STEP,
  parameter int unsigned X1_INIT     = DEF_X1_INIT,
  parameter int unsigned X2_INIT     = DEF_X2_INIT,
  parameter int unsigned LIVES_INIT  = DEF_LIVES_INIT,
  parameter int unsigned OVER_FRAMES = DEF_OVER_FRAMES,
  parameter int unsigned SPEED_STEP  = DEF_SPEED_STEP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_flag1,
  input  logic               key_flag2,
  input  logic               key_flag3,
  input  logic               key_flag4,
  input  logic               frame_tick,
  game_sequencer_if.master   sq_if,
  output logic [9:0]         x,
  output logic [9:0]         x2,
  output logic [7:0]         score1,
  output logic [7:0]         score2,
  output logic [2:0]         lives,
  output logic [STATE_W-1:0] game_state
);

  localparam int unsigned HC_W = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;
  localparam int unsigned FC_W = $clog2(OVER_FRAMES + 1);

  localparam logic [HC_W-1:0] HC_LAST  = HC_W'(SPEED_STEP - 1);
  localparam logic [FC_W-1:0] FC_DONE  = FC_W'(OVER_FRAMES);
  localparam logic [9:0]      X1_START = 10'(X1_INIT);
  localparam logic [9:0]      X2_START = 10'(X2_INIT);
  localparam logic [2:0]      LIVES0   = 3'(LIVES_INIT);

  state_t          state_q, state_d;
  logic [9:0]      x_q, x_d, x2_q, x2_d, x_step, x2_step;
  logic [7:0]      score1_q, score1_d, score2_q, score2_d;
  logic [2:0]      lives_q, lives_d, speed_q, speed_d;
  logic            move_en_q, move_en_d, respawn_q, respawn_d;
  logic [3:0]      pend_q, pend_d;
  logic [HC_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;

  logic [3:0] keys, eff;
  logic       key_any, hit_any, want_respawn;

  // Bit order: 0 = P1 left, 1 = P1 right, 2 = P2 left, 3 = P2 right
  assign keys    = {key_flag4, key_flag3, key_flag2, key_flag1};
  assign key_any = |keys;
  assign eff     = pend_q | keys;
  assign hit_any = sq_if.hit1 | sq_if.hit2;

  paddle_step #(.X_MIN(X_MIN), .X_MAX(X_MAX), .PW(PW), .STEP(STEP)) u_step1 (
    .pos(x_q), .left(eff[0]), .right(eff[1]), .pos_next(x_step)
  );

  paddle_step #(.X_MIN(X_MIN), .X_MAX(X_MAX), .PW(PW), .STEP(STEP)) u_step2 (
    .pos(x2_q), .left(eff[2]), .right(eff[3]), .pos_next(x2_step)
  );

  // Next-state and next-output computation for the whole game
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    x2_d         = x2_q;
    score1_d     = score1_q;
    score2_d     = score2_q;
    lives_d      = lives_q;
    speed_d      = speed_q;
    hit_cnt_d    = hit_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    pend_d       = pend_q | keys;
    want_respawn = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (key_any) begin
          state_d      = ST_PLAY;
          x_d          = X1_START;
          x2_d         = X2_START;
          score1_d     = '0;
          score2_d     = '0;
          lives_d      = LIVES0;
          speed_d      = 3'd1;
          hit_cnt_d    = '0;
          want_respawn = 1'b1;
        end
      end
      ST_PLAY: begin
        if (frame_tick) begin
          x_d    = x_step;
          x2_d   = x2_step;
          pend_d = '0;
        end
        if (hit_any) begin
          if (sq_if.hit1) score1_d = sat_inc8(score1_q);
          if (sq_if.hit2) score2_d = sat_inc8(score2_q);
          want_respawn = 1'b1;
          if (hit_cnt_q == HC_LAST) begin
            hit_cnt_d = '0;
            if (speed_q != 3'd7) speed_d = speed_q + 3'd1;
          end else begin
            hit_cnt_d = hit_cnt_q + 1'b1;
          end
        end else if (sq_if.sq_bottom) begin
          lives_d = lives_q - 3'd1;
          if (lives_q == 3'd1) begin
            state_d     = ST_OVER;
            frame_cnt_d = '0;
          end else begin
            want_respawn = 1'b1;
          end
        end
      end
      ST_OVER: begin
        if (frame_tick && frame_cnt_q != FC_DONE) frame_cnt_d = frame_cnt_q + 1'b1;
        if (key_any && frame_cnt_q == FC_DONE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) pend_d = '0;
    // Suppressing back-to-back requests keeps respawn a strict single-cycle pulse
    respawn_d = want_respawn && !respawn_q;
    move_en_d = (state_d == ST_PLAY);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= X1_START;
      x2_q        <= X2_START;
      score1_q    <= '0;
      score2_q    <= '0;
      lives_q     <= LIVES0;
      speed_q     <= 3'd1;
      move_en_q   <= 1'b0;
      respawn_q   <= 1'b0;
      pend_q      <= '0;
      hit_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      x2_q        <= x2_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      lives_q     <= lives_d;
      speed_q     <= speed_d;
      move_en_q   <= move_en_d;
      respawn_q   <= respawn_d;
      pend_q      <= pend_d;
      hit_cnt_q   <= hit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign x                = x_q;
  assign x2               = x2_q;
  assign score1           = score1_q;
  assign score2           = score2_q;
  assign lives            = lives_q;
  assign game_state       = state_q;
  assign sq_if.speed      = speed_q;
  assign sq_if.move_en    = move_en_q;
  assign sq_if.sq_respawn = respawn_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer.
module tb_game_sequencer;

  logic       clk;
  logic       rst_n;
  logic [3:0] kf;
  logic       frame_tick;

  logic [9:0] x, x2, xb, x2b;
  logic [7:0] score1, score2, score1b, score2b;
  logic [2:0] lives, livesb;
  logic [1:0] game_state, game_stateb;

  int vecs;
  int errs;
  int rs_first, rs_second;

  game_sequencer_if sq_if ();
  game_sequencer_if sq_if_b ();

  assign sq_if_b.hit1      = 1'b0;
  assign sq_if_b.hit2      = 1'b0;
  assign sq_if_b.sq_bottom = 1'b0;

  game_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .key_flag1(kf[0]), .key_flag2(kf[1]), .key_flag3(kf[2]), .key_flag4(kf[3]),
    .frame_tick(frame_tick), .sq_if(sq_if),
    .x(x), .x2(x2), .score1(score1), .score2(score2),
    .lives(lives), .game_state(game_state)
  );

  // Second instance starts near both screen edges to reach the clamp cases
  game_sequencer #(.X1_INIT(4), .X2_INIT(732)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .key_flag1(kf[0]), .key_flag2(kf[1]), .key_flag3(kf[2]), .key_flag4(kf[3]),
    .frame_tick(frame_tick), .sq_if(sq_if_b),
    .x(xb), .x2(x2b), .score1(score1b), .score2(score2b),
    .lives(livesb), .game_state(game_stateb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of inputs, then return them to idle
  task automatic drive(input logic [3:0] k, input logic ft, input logic h1,
                       input logic h2, input logic b);
    kf = k; frame_tick = ft;
    sq_if.hit1 = h1; sq_if.hit2 = h2; sq_if.sq_bottom = b;
    tick();
    kf = '0; frame_tick = 1'b0;
    sq_if.hit1 = 1'b0; sq_if.hit2 = 1'b0; sq_if.sq_bottom = 1'b0;
  endtask

  // Drive one cycle, record sq_respawn in that cycle's result and the one after
  task automatic drive_rs(input logic h1, input logic h2, input logic b);
    drive(4'b0000, 1'b0, h1, h2, b);
    rs_first = int'(sq_if.sq_respawn);
    tick();
    rs_second = int'(sq_if.sq_respawn);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; kf = '0; frame_tick = 1'b0;
    sq_if.hit1 = 1'b0; sq_if.hit2 = 1'b0; sq_if.sq_bottom = 1'b0;
    #22 rst_n = 1'b1;
    tick();
    vecs++;
    if ({game_state, x, x2, score1, score2, lives, sq_if.speed, sq_if.move_en, sq_if.sq_respawn}
        !== {2'd0, 10'd200, 10'd536, 8'd0, 8'd0, 3'd3, 3'd1, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL reset: state=%0d x=%0d x2=%0d s1=%0d s2=%0d lives=%0d speed=%0d mv=%0b rs=%0b, need 0 200 536 0 0 3 1 0 0",
               game_state, x, x2, score1, score2, lives, sq_if.speed, sq_if.move_en, sq_if.sq_respawn);
    end
  endtask

  task automatic test_start();
    drive(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs++;
    if ({game_state, sq_if.sq_respawn, sq_if.move_en, x, x2, lives} !== {2'd1, 1'b1, 1'b1, 10'd200, 10'd536, 3'd3}) begin
      errs++;
      $display("FAIL start: state=%0d rs=%0b mv=%0b x=%0d x2=%0d lives=%0d, need 1 1 1 200 536 3",
               game_state, sq_if.sq_respawn, sq_if.move_en, x, x2, lives);
    end
    vecs++;
    if ({xb, x2b} !== {10'd4, 10'd732}) begin
      errs++;
      $display("FAIL start_b: x=%0d x2=%0d, need 4 732", xb, x2b);
    end
    tick();
    vecs++;
    if (sq_if.sq_respawn !== 1'b0) begin
      errs++;
      $display("FAIL start_rs_once: rs=%0b, need 0", sq_if.sq_respawn);
    end
  endtask

  task automatic test_pending();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    vecs++;
    if (x !== 10'd200) begin
      errs++;
      $display("FAIL hold_until_frame: x=%0d, need 200", x);
    end
    drive(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs++;
    if ({x, xb} !== {10'd208, 10'd12}) begin
      errs++;
      $display("FAIL collapse: x=%0d xb=%0d, need 208 12", x, xb);
    end
    drive(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs++;
    if ({x, xb} !== {10'd208, 10'd12}) begin
      errs++;
      $display("FAIL cancel: x=%0d xb=%0d, need 208 12", x, xb);
    end
  endtask

  task automatic test_boundaries();
    drive(4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs++;
    if ({x, x2, xb, x2b} !== {10'd200, 10'd544, 10'd4, 10'd736}) begin
      errs++;
      $display("FAIL step1: x=%0d x2=%0d xb=%0d x2b=%0d, need 200 544 4 736", x, x2, xb, x2b);
    end
    drive(4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs++;
    if ({x, x2, xb, x2b} !== {10'd192, 10'd552, 10'd0, 10'd736}) begin
      errs++;
      $display("FAIL clamp: x=%0d x2=%0d xb=%0d x2b=%0d, need 192 552 0 736", x, x2, xb, x2b);
    end
    // Key arriving in the same cycle as frame_tick is applied immediately
    drive(4'b1001, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs++;
    if ({x, x2, xb, x2b} !== {10'd184, 10'd560, 10'd0, 10'd736}) begin
      errs++;
      $display("FAIL same_cycle_key: x=%0d x2=%0d xb=%0d x2b=%0d, need 184 560 0 736", x, x2, xb, x2b);
    end
  endtask

  task automatic test_hits();
    int rs_cnt;
    drive_rs(1'b1, 1'b1, 1'b0);
    vecs++;
    if ({score1, score2, 2'(rs_first), 2'(rs_second)} !== {8'd1, 8'd1, 2'd1, 2'd0}) begin
      errs++;
      $display("FAIL dual_hit: s1=%0d s2=%0d rs=%0d,%0d, need 1 1 1,0", score1, score2, rs_first, rs_second);
    end
    rs_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      drive_rs(1'b1, 1'b0, 1'b0);
      rs_cnt += rs_first + rs_second;
    end
    vecs++;
    if ({sq_if.speed, score1, 4'(rs_cnt)} !== {3'd2, 8'd5, 4'd4}) begin
      errs++;
      $display("FAIL speed_step: speed=%0d s1=%0d respawns=%0d, need 2 5 4", sq_if.speed, score1, rs_cnt);
    end
    for (int i = 0; i < 25; i++) drive_rs(1'b1, 1'b0, 1'b0);
    vecs++;
    if (sq_if.speed !== 3'd7) begin
      errs++;
      $display("FAIL speed_30: speed=%0d, need 7", sq_if.speed);
    end
    for (int i = 0; i < 5; i++) drive_rs(1'b1, 1'b0, 1'b0);
    vecs++;
    if ({sq_if.speed, score1} !== {3'd7, 8'd35}) begin
      errs++;
      $display("FAIL speed_sat: speed=%0d s1=%0d, need 7 35", sq_if.speed, score1);
    end
  endtask

  task automatic test_back_to_back();
    drive(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs++;
    if ({sq_if.sq_respawn, score1} !== {1'b0, 8'd37}) begin
      errs++;
      $display("FAIL b2b_respawn: rs=%0b s1=%0d, need 0 37", sq_if.sq_respawn, score1);
    end
    tick();
    for (int i = 0; i < 260; i++) drive(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs++;
    if (score2 !== 8'd255) begin
      errs++;
      $display("FAIL score_sat: s2=%0d, need 255", score2);
    end
    tick();
  endtask

  task automatic test_bottom();
    drive_rs(1'b1, 1'b0, 1'b1);
    vecs++;
    if ({lives, score1, 2'(rs_first)} !== {3'd3, 8'd38, 2'd1}) begin
      errs++;
      $display("FAIL hit_beats_bottom: lives=%0d s1=%0d rs=%0d, need 3 38 1", lives, score1, rs_first);
    end
    drive_rs(1'b0, 1'b0, 1'b1);
    drive_rs(1'b0, 1'b0, 1'b1);
    vecs++;
    if ({lives, 2'(rs_first), game_state} !== {3'd1, 2'd1, 2'd1}) begin
      errs++;
      $display("FAIL lives_dec: lives=%0d rs=%0d state=%0d, need 1 1 1", lives, rs_first, game_state);
    end
    drive_rs(1'b0, 1'b0, 1'b1);
    vecs++;
    if ({lives, game_state, sq_if.move_en, 2'(rs_first), 2'(rs_second)} !== {3'd0, 2'd2, 1'b0, 2'd0, 2'd0}) begin
      errs++;
      $display("FAIL game_over: lives=%0d state=%0d mv=%0b rs=%0d,%0d, need 0 2 0 0,0",
               lives, game_state, sq_if.move_en, rs_first, rs_second);
    end
  endtask

  task automatic test_over();
    drive(4'b0001, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 119; i++) drive(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs++;
    if ({game_state, lives, score1} !== {2'd2, 3'd0, 8'd38}) begin
      errs++;
      $display("FAIL over_hold: state=%0d lives=%0d s1=%0d, need 2 0 38", game_state, lives, score1);
    end
    drive(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs++;
    if ({game_state, sq_if.move_en, score1, score2} !== {2'd0, 1'b0, 8'd38, 8'd255}) begin
      errs++;
      $display("FAIL over_exit: state=%0d mv=%0b s1=%0d s2=%0d, need 0 0 38 255",
               game_state, sq_if.move_en, score1, score2);
    end
  endtask

  task automatic test_async_reset();
    drive(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs++;
    if ({game_state, score1, score2, lives, sq_if.speed} !== {2'd1, 8'd0, 8'd0, 3'd3, 3'd1}) begin
      errs++;
      $display("FAIL replay_entry: state=%0d s1=%0d s2=%0d lives=%0d speed=%0d, need 1 0 0 3 1",
               game_state, score1, score2, lives, sq_if.speed);
    end
    tick();
    drive(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({game_state, x, x2, score1, lives, sq_if.speed, sq_if.move_en, sq_if.sq_respawn}
        !== {2'd0, 10'd200, 10'd536, 8'd0, 3'd3, 3'd1, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL async_reset: state=%0d x=%0d x2=%0d s1=%0d lives=%0d speed=%0d mv=%0b rs=%0b, need 0 200 536 0 3 1 0 0",
               game_state, x, x2, score1, lives, sq_if.speed, sq_if.move_en, sq_if.sq_respawn);
    end
    #10 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_start();
    test_pending();
    test_boundaries();
    test_hits();
    test_back_to_back();
    test_bottom();
    test_over();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Frame-locked game controller in the CLOCK_50 domain. It sits between the four key_filter pulse outputs and the square/render datapath.
- Owns the game FSM (idle/play/over), player paddle positions x/x2, scores, lives and falling-square speed.
- Sequences square_logic through a respawn pulse, a move enable and a speed level, so that all game-state updates happen once per video frame.

Parameters:
- X_MIN, 0, leftmost legal paddle x
- X_MAX, 800, screen width in pixels (paddle right edge is limited to X_MAX)
- PW, 64, paddle width in pixels
- STEP, 8, pixels moved per applied key press
- X1_INIT, 200, player-1 start x
- X2_INIT, 536, player-2 start x
- LIVES_INIT, 3, lives at game start (max 7)
- OVER_FRAMES, 120, frames the OVER screen is held before a key is accepted
- SPEED_STEP, 5, total hits per speed level increment

Ports:
- clk  in  1  CLOCK_50 domain clock
- rst_n  in  1  asynchronous active-low reset (driven by PLL locked)
- key_flag1  in  1  one-cycle pulse: player-1 left
- key_flag2  in  1  one-cycle pulse: player-1 right
- key_flag3  in  1  one-cycle pulse: player-2 left
- key_flag4  in  1  one-cycle pulse: player-2 right
- frame_tick  in  1  one-cycle pulse per frame, already synchronised to clk
- hit1  in  1  pulse: square collided with player-1 paddle
- hit2  in  1  pulse: square collided with player-2 paddle
- sq_bottom  in  1  pulse: square reached the bottom unhit
- x  out  10  player-1 paddle left x
- x2  out  10  player-2 paddle left x
- score1  out  8  player-1 score, saturates at 255
- score2  out  8  player-2 score, saturates at 255
- lives  out  3  remaining lives
- speed  out  3  square fall speed, 1..7
- move_en  out  1  square_logic may advance; high only in PLAY
- sq_respawn  out  1  one-cycle pulse: square_logic re-randomises the square
- game_state  out  2  0 = IDLE, 1 = PLAY, 2 = OVER

Behaviour:
Reset (async, rst_n = 0):
- state = IDLE; x = X1_INIT; x2 = X2_INIT.
- score1 = score2 = 0; lives = LIVES_INIT; speed = 1.
- move_en = 0; sq_respawn = 0; all pending bits, hit counter and frame counter cleared.
- Reset asserted mid-game aborts immediately; there is no state retention.

All outputs are registered.

Key latching:
- Each key_flag pulse sets a sticky pending bit (pL1, pR1, pL2, pR2) in every state.
- On frame_tick in PLAY, the pending bits plus any key pulse arriving in that same cycle are applied, then all pending bits are cleared.
- Multiple pulses within one frame collapse to one step.
- Left and right pending for the same player cancel: no move, bits still cleared.
- Pending bits are cleared on every state transition.

Movement, applied in the cycle after frame_tick; 10-bit unsigned arithmetic with no wrap:
- Left: if x < X_MIN+STEP then x = X_MIN, else x = x-STEP.
- Right: if x > X_MAX-PW-STEP then x = X_MAX-PW, else x = x+STEP.
- Same rules apply to x2.

FSM:
- IDLE:
  - move_en = 0.
  - Any key_flag pulse -> PLAY.
  - On entry to PLAY: x/x2 reload their INIT values, scores = 0, lives = LIVES_INIT, speed = 1, hit counter = 0, and one sq_respawn pulse is issued.
- PLAY:
  - move_en = 1.
  - hit1 increments score1 (saturating); hit2 increments score2 (saturating). If both arrive in the same cycle, both scores increment.
  - Any hit in a cycle issues exactly one sq_respawn (next cycle) and increments the hit counter once.
  - When the hit counter reaches SPEED_STEP it returns to 0 and speed increments (saturating at 7).
  - sq_bottom without a hit in the same cycle: lives decrements and sq_respawn is issued. If the hit and sq_bottom coincide, the hit wins and no life is lost.
  - A decrement from lives = 1 -> OVER, with lives = 0 and no respawn.
- OVER:
  - move_en = 0; the frame counter counts frame_ticks.
  - Key pulses are ignored until the count reaches OVER_FRAMES.
  - After that, any key_flag pulse -> IDLE. Scores are held until the next PLAY entry.

Other rules:
- sq_respawn is never high on two consecutive cycles.
- Hit and bottom inputs are ignored outside PLAY.

Decomposition:
- game_pkg holds:
  - state encodings ST_IDLE, ST_PLAY, ST_OVER;
  - the 2-bit state width;
  - default constants for the screen and paddle geometry.
- Sub-module paddle_step (combinational): inputs pos, left, right; output clamped next position. Instanced twice.
- The FSM, counters and pending latches stay in game_sequencer.

Test Plan:
1. Reset, then one key_flag1 pulse -> game_state = 1, sq_respawn pulses once, x = 200, x2 = 536, lives = 3.
2. In PLAY, three key_flag2 pulses in one frame, then frame_tick -> x = 208 (single step). Same test with key_flag1 and key_flag2 together -> x unchanged.
3. x = 4, key_flag1, frame_tick -> x = 0. x = 732, key_flag2, frame_tick -> x = 736. Further right presses keep x = 736.
4. hit1 and hit2 in the same cycle -> score1 = 1, score2 = 1, exactly one sq_respawn. Five single hits -> speed = 2. Thirty-five hits total -> speed saturates at 7.
5. hit1 and sq_bottom in the same cycle -> lives unchanged, score1 incremented. Three lone sq_bottom pulses -> lives = 0, game_state = 2, move_en = 0, no respawn on the third.
6. In OVER, a key before 120 frame_ticks is ignored. After 120 frame_ticks, a key returns game_state to 0. rst_n low mid-PLAY returns all outputs to reset values asynchronously.
